// File: rtl/echo_delay_line_if.sv
// Port bundle for the echo delay line: sample strobe in, delayed tap strobe out,
// plus the clear request and status flags.
`timescale 1ns/1ps
interface echo_delay_line_if #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4096,
  parameter int GAIN_W = 16
);
  localparam int AW = $clog2(DEPTH);

  // Strobe semantics: there is no ready. in_valid is a one-cycle strobe carrying
  // in_sample/delay_len/fb_gain; if the block cannot take it, the sample is lost
  // and overrun pulses on the following cycle. out_valid is a one-cycle strobe
  // and out_sample holds its value until the next out_valid.
  logic                     in_valid;
  logic signed [WIDTH-1:0]  in_sample;
  logic [AW-1:0]            delay_len;
  logic signed [GAIN_W-1:0] fb_gain;
  logic                     clear;
  logic                     out_valid;
  logic signed [WIDTH-1:0]  out_sample;
  logic                     busy;
  logic                     overrun;
  logic [1:0]               dbg_state;

  modport master (
    output in_valid, in_sample, delay_len, fb_gain, clear,
    input  out_valid, out_sample, busy, overrun, dbg_state
  );

  modport slave (
    input  in_valid, in_sample, delay_len, fb_gain, clear,
    output out_valid, out_sample, busy, overrun, dbg_state
  );
endinterface

// File: rtl/echo_delay_line.sv
// Circular-buffer echo delay with runtime delay length and saturating feedback.
// One accepted sample occupies IDLE -> READ -> CALC; the RAM is zeroed by a sweep after reset.
`timescale 1ns/1ps
module echo_delay_line #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4096,
  parameter int GAIN_W = 16
) (
  input logic clk,
  input logic rst,
  echo_delay_line_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_READ = 2'd2, S_CALC = 2'd3} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic signed [WIDTH-1:0]  in_q, in_d;
  logic signed [GAIN_W-1:0] gain_q, gain_d;
  logic signed [WIDTH-1:0]  wval_q, wval_d;
  logic signed [WIDTH-1:0]  out_sample_q, out_sample_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     clr_pend_q, clr_pend_d;

  logic signed [WIDTH-1:0]  mem [DEPTH];
  logic signed [WIDTH-1:0]  rdata_q;
  logic                     accept;
  logic [AW-1:0]            d_eff;
  logic [AW-1:0]            rd_addr;
  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic signed [WIDTH-1:0]  mem_wdata;

  logic signed [WIDTH+GAIN_W-1:0] prod;
  logic signed [WIDTH:0]          fb;
  logic signed [WIDTH:0]          sum;
  logic signed [WIDTH-1:0]        wval;

  // A zero delay would read the slot about to be written, so it is promoted to 1.
  assign d_eff   = (bus.delay_len == '0) ? AW'(1) : bus.delay_len;
  assign rd_addr = wr_ptr_q - d_eff;

  assign prod = rdata_q * gain_q;
  assign fb   = (WIDTH+1)'(prod >>> (GAIN_W-1));
  assign sum  = {in_q[WIDTH-1], in_q} + fb;

  always_comb begin
    wval = sum[WIDTH-1:0];
    if (sum[WIDTH] != sum[WIDTH-1]) wval = sum[WIDTH] ? SMIN : SMAX;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (state_q == S_CALC) begin
      mem_we    = 1'b1;
      mem_waddr = wr_ptr_q;
      mem_wdata = wval_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) rdata_q <= mem[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    in_d         = in_q;
    gain_d       = gain_q;
    wval_d       = wval_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    overrun_d    = 1'b0;
    clr_pend_d   = clr_pend_q;
    accept       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        cnt_d     = cnt_q + AW'(1);
        overrun_d = bus.in_valid;
        if (cnt_q == AW'(DEPTH-1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        // A pending or fresh clear outranks a simultaneous sample.
        if (bus.clear || clr_pend_q) begin
          state_d    = S_CLEAR;
          cnt_d      = '0;
          wr_ptr_d   = '0;
          clr_pend_d = 1'b0;
          overrun_d  = bus.in_valid;
        end else if (bus.in_valid) begin
          accept  = 1'b1;
          in_d    = bus.in_sample;
          gain_d  = bus.fb_gain;
          state_d = S_READ;
        end
      end
      S_READ: begin
        wval_d       = wval;
        out_sample_d = rdata_q;
        out_valid_d  = 1'b1;
        overrun_d    = bus.in_valid;
        clr_pend_d   = clr_pend_q | bus.clear;
        state_d      = S_CALC;
      end
      S_CALC: begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        overrun_d  = bus.in_valid;
        clr_pend_d = clr_pend_q | bus.clear;
        state_d    = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      in_q         <= '0;
      gain_q       <= '0;
      wval_q       <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      in_q         <= in_d;
      gain_q       <= gain_d;
      wval_q       <= wval_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q == S_CLEAR);
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line: vector table, corner-case sequences and random
// traffic checked against a sample-history model of the echo recurrence.
`timescale 1ns/1ps
module tb_echo_delay_line;
  localparam int WIDTH  = 24;
  localparam int DEPTH  = 16;
  localparam int GAIN_W = 16;
  localparam int AW     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, ovr_seen = 0, ovr_exp = 0;
  logic [WIDTH-1:0] exp_q[$];
  int hist[$];

  typedef struct {
    logic [WIDTH-1:0]  s;
    logic [AW-1:0]     dl;
    logic [GAIN_W-1:0] g;
    int                gap;
    bit                clr;
    logic [WIDTH-1:0]  exp;
  } vec_t;
  vec_t vecs[$];

  echo_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAIN_W(GAIN_W)) bus();
  echo_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want no output", $unsigned(bus.out_sample));
      end else begin
        check("out_sample", $unsigned(bus.out_sample), exp_q.pop_front());
      end
    end
    if (bus.overrun) ovr_seen++;
  end

  // Reference: buf[n] = sat(in[n] + floor(g * out[n] / 2^15)), out[n] = buf[n-D] (0 before start).
  task automatic model_push(input logic [WIDTH-1:0] s, input logic [AW-1:0] dl, input logic [GAIN_W-1:0] g);
    int d, n, tap;
    longint p, fbv, sum;
    d   = (dl == 0) ? 1 : int'(dl);
    n   = hist.size();
    tap = (n >= d) ? hist[n-d] : 0;
    p   = longint'(tap) * longint'($signed(g));
    fbv = p / 32768;
    if (p < 0 && (p % 32768) != 0) fbv = fbv - 1;
    sum = longint'($signed(s)) + fbv;
    if (sum > 8388607) sum = 8388607;
    if (sum < -8388608) sum = -8388608;
    hist.push_back(int'(sum));
    exp_q.push_back(WIDTH'(tap));
  endtask

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic pulse_in(input bit v, input logic [WIDTH-1:0] s, input logic [AW-1:0] dl,
                          input logic [GAIN_W-1:0] g, input bit clr);
    bus.in_valid = v; bus.in_sample = s; bus.delay_len = dl; bus.fb_gain = g; bus.clear = clr;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic drive_sample(input logic [WIDTH-1:0] s, input logic [AW-1:0] dl,
                              input logic [GAIN_W-1:0] g, input int gap);
    pulse_in(1'b1, s, dl, g, 1'b0);
    @(negedge clk);
    check("latency_t2", bus.out_valid, 1);
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_model(input logic [WIDTH-1:0] s, input logic [AW-1:0] dl,
                            input logic [GAIN_W-1:0] g, input int gap);
    model_push(s, dl, g);
    drive_sample(s, dl, g, gap);
  endtask

  task automatic do_clear(input bit with_valid);
    pulse_in(with_valid, 24'h00_0055, 4'd1, 16'h0, 1'b1);
    if (with_valid) ovr_exp++;
    check("clear_busy_on", bus.busy, 1);
    repeat (16) @(negedge clk);
    check("clear_busy_off", bus.busy, 0);
    hist.delete();
  endtask

  function automatic void add_vec(input logic [WIDTH-1:0] s, input logic [AW-1:0] dl,
                                  input logic [GAIN_W-1:0] g, input int gap, input bit clr,
                                  input logic [WIDTH-1:0] e);
    vec_t v;
    v.s = s; v.dl = dl; v.g = g; v.gap = gap; v.clr = clr; v.exp = e;
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int busy_cnt, ov_cnt;
    bus.in_valid = 0; bus.in_sample = '0; bus.delay_len = '0; bus.fb_gain = '0; bus.clear = 0;

    // Pure delay D=4, spacing 4.
    for (int i = 1; i <= 7; i++)
      add_vec(WIDTH'(i), 4'd4, 16'h0, 1, (i == 1), (i <= 4) ? '0 : WIDTH'(i - 4));
    // Feedback D=2, gain 0.5, impulse.
    add_vec(24'h100000, 4'd2, 16'h4000, 0, 1'b1, 24'h000000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h000000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h100000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h000000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h080000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h000000);
    add_vec(24'h000000, 4'd2, 16'h4000, 0, 1'b0, 24'h040000);
    // Positive saturation, then gain -1.0 on the most-negative tap, then delay_len=0.
    add_vec(24'h700000, 4'd1, 16'h7FFF, 0, 1'b1, 24'h000000);
    add_vec(24'h700000, 4'd1, 16'h7FFF, 0, 1'b0, 24'h700000);
    add_vec(24'h700000, 4'd1, 16'h7FFF, 0, 1'b0, 24'h7FFFFF);
    add_vec(24'h700000, 4'd1, 16'h7FFF, 0, 1'b0, 24'h7FFFFF);
    add_vec(24'h800000, 4'd1, 16'h0000, 0, 1'b0, 24'h7FFFFF);
    add_vec(24'h000000, 4'd1, 16'h8000, 0, 1'b0, 24'h800000);
    add_vec(24'h000000, 4'd1, 16'h0000, 0, 1'b0, 24'h7FFFFF);
    add_vec(24'h000005, 4'd0, 16'h0000, 0, 1'b0, 24'h000000);
    add_vec(24'h000009, 4'd0, 16'h0000, 0, 1'b0, 24'h000005);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", $unsigned(bus.out_sample), 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_busy", bus.busy, 1);

    // Post-reset sweep with a sample landing in cycle 5.
    @(posedge clk); #1 rst = 1'b0;
    busy_cnt = 0; ov_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) ov_cnt++;
      bus.in_valid = (k == 5);
    end
    bus.in_valid = 1'b0;
    ovr_exp++;
    check("busy_cycles", busy_cnt, DEPTH);
    check("sweep_no_out", ov_cnt, 0);
    check("sweep_overrun", ovr_seen, ovr_exp);

    // Vector table.
    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear(1'b0);
      exp_q.push_back(vecs[i].exp);
      drive_sample(vecs[i].s, vecs[i].dl, vecs[i].g, vecs[i].gap);
    end
    check("table_drain", exp_q.size(), 0);

    // Maximum delay across pointer wrap.
    do_clear(1'b0);
    for (int i = 0; i < 40; i++) send_model(WIDTH'($urandom), 4'd15, 16'h0, 0);

    // Random traffic: any delay (incl. 0), any gain, random gaps.
    do_clear(1'b0);
    for (int i = 0; i < 80; i++)
      send_model(WIDTH'($urandom), AW'($urandom_range(0, 15)), GAIN_W'($urandom), $urandom_range(0, 2));
    check("random_drain", exp_q.size(), 0);

    // Second strobe two cycles after the first is dropped.
    do_clear(1'b0);
    model_push(24'h000ABC, 4'd1, 16'h0);
    pulse_in(1'b1, 24'h000ABC, 4'd1, 16'h0, 1'b0);
    @(negedge clk);
    check("collide_lat", bus.out_valid, 1);
    pulse_in(1'b1, 24'h000DEF, 4'd1, 16'h0, 1'b0);
    ovr_exp++;
    repeat (3) @(negedge clk);
    check("collide_overrun", ovr_seen, ovr_exp);
    send_model(24'h000111, 4'd1, 16'h0, 0);

    // Clear and sample together in IDLE.
    do_clear(1'b1);
    check("clear_valid_overrun", ovr_seen, ovr_exp);

    // Clear during READ is deferred until the sample completes.
    model_push(24'h000222, 4'd1, 16'h0);
    pulse_in(1'b1, 24'h000222, 4'd1, 16'h0, 1'b0);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("defer_out", bus.out_valid, 1);
    @(negedge clk);
    check("defer_idle", bus.busy, 0);
    @(negedge clk);
    check("defer_clear", bus.busy, 1);
    hist.delete();
    repeat (16) @(negedge clk);
    check("defer_done", bus.busy, 0);

    // Reset asserted while the output strobe is up.
    send_model(24'h123456, 4'd1, 16'h0, 0);
    model_push(24'h000001, 4'd1, 16'h0);
    pulse_in(1'b1, 24'h000001, 4'd1, 16'h0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_sample", $unsigned(bus.out_sample), 0);
    check("midrst_busy", bus.busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    hist.delete();
    repeat (DEPTH + 4) @(negedge clk);
    check("midrst_sweep_done", bus.busy, 0);
    send_model(24'h000777, 4'd3, 16'h0, 0);
    send_model(24'h000888, 4'd1, 16'h0, 0);

    // ---------------- final report ----------------
    repeat (4) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    check("final_overrun", ovr_seen, ovr_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
